// File: rtl/ad_block_sequencer_if.sv
// rtl/ad_block_sequencer_if.sv - AD block offer/accept bundle between the sequencer and its consumer.
interface ad_block_sequencer_if #(
  parameter int RATE_BYTES = 8,
  parameter int LEN_W      = 8
);
  localparam int DL_W = $clog2(RATE_BYTES) + 1;

  logic             busy;
  logic             AD_read;
  logic [LEN_W-1:0] AD_len;
  logic             block_request;
  logic             AD_cntrl;
  logic [DL_W-1:0]  datalen;
  logic             last_block;
  logic             pad_block;
  logic             ad_done;
  logic [LEN_W-1:0] block_idx;

  modport master (
    input  busy, AD_read, AD_len,
    output block_request, AD_cntrl, datalen, last_block, pad_block, ad_done, block_idx
  );

  modport slave (
    output busy, AD_read, AD_len,
    input  block_request, AD_cntrl, datalen, last_block, pad_block, ad_done, block_idx
  );
endinterface

// File: rtl/ad_block_sequencer.sv
// rtl/ad_block_sequencer.sv - splits associated data into rate-sized blocks plus optional padding block.
module ad_block_sequencer #(
  parameter int RATE_BYTES = 8,
  parameter int LEN_W      = 8
) (
  input  logic                 clk,
  input  logic                 nRST,
  ad_block_sequencer_if.master bus
);
  localparam int DL_W = $clog2(RATE_BYTES) + 1;
  localparam logic [LEN_W-1:0] RATE_L = LEN_W'(RATE_BYTES);

  typedef enum logic [1:0] {IDLE, ACTIVE, PAD, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] idx;
  logic             done_flag;

  logic            short_blk;
  logic [DL_W-1:0] cur_len;

  // A short block is the final one; an exact multiple of the rate needs a trailing pad block.
  assign short_blk = (rem < RATE_L);
  assign cur_len   = short_blk ? DL_W'(rem) : DL_W'(RATE_BYTES);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      rem       <= '0;
      idx       <= '0;
      done_flag <= 1'b0;
    end else if (!bus.busy) begin
      state     <= IDLE;
      rem       <= '0;
      idx       <= '0;
      done_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.AD_len == '0) begin
            state     <= DONE;
            done_flag <= 1'b1;
          end else begin
            rem   <= bus.AD_len;
            idx   <= '0;
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (bus.AD_read) begin
            rem <= rem - LEN_W'(cur_len);
            idx <= idx + LEN_W'(1);
            if (short_blk) begin
              state     <= DONE;
              done_flag <= 1'b1;
            end else if (rem == RATE_L) begin
              state <= PAD;
            end
          end
        end
        PAD: begin
          if (bus.AD_read) begin
            idx       <= idx + LEN_W'(1);
            state     <= DONE;
            done_flag <= 1'b1;
          end
        end
        DONE: begin
          done_flag <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.block_request = (state == ACTIVE) || (state == PAD);
  assign bus.AD_cntrl      = (state == ACTIVE) || (state == PAD);
  assign bus.datalen       = (state == ACTIVE) ? cur_len : '0;
  assign bus.last_block    = ((state == ACTIVE) && short_blk) || (state == PAD);
  assign bus.pad_block     = (state == PAD);
  assign bus.ad_done       = done_flag;
  assign bus.block_idx     = idx;
endmodule

// File: doc/ad_block_sequencer.md
AD_BLOCK_SEQUENCER -- requirements
Module: ad_block_sequencer

Interface
REQ-001 Parameter RATE_BYTES, default 8, rate block size in bytes; legal values 8 (ASCON-128) and 16 (ASCON-128a).
REQ-002 Parameter LEN_W, default 8, width of the AD byte-length input and block counter.
REQ-003 Derived constant DL_W = $clog2(RATE_BYTES)+1, width of datalen.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 nRST  input  1  reset, asynchronous, active-low.
REQ-006 busy  input  1  operation in progress; deassertion aborts the sequence.
REQ-007 AD_read  input  1  consumer accepts the current block this cycle.
REQ-008 AD_len  input  LEN_W  total AD length in bytes; sampled only at sequence start.
REQ-009 block_request  output  1  a block (data or pad) is offered this cycle.
REQ-010 AD_cntrl  output  1  AD phase owns the datapath.
REQ-011 datalen  output  DL_W  valid bytes in the offered block, 0..RATE_BYTES.
REQ-012 last_block  output  1  offered block is the final AD block.
REQ-013 pad_block  output  1  offered block is a padding-only block (datalen=0).
REQ-014 ad_done  output  1  one-cycle pulse: AD phase complete.
REQ-015 block_idx  output  LEN_W  index of the offered block, 0-based.

Function
REQ-016 States SHALL be IDLE, ACTIVE, PAD, DONE; outputs SHALL be Moore (decoded from state and registers only).
REQ-017 Registers SHALL be rem (LEN_W, bytes remaining), block_idx (LEN_W) and a done-pulse flag.
REQ-018 IDLE: block_request=0, AD_cntrl=0, datalen=0, last_block=0, pad_block=0.
REQ-019 IDLE, busy=1, AD_len=0 -> DONE next cycle; no block is offered.
REQ-020 IDLE, busy=1, AD_len!=0 -> rem<=AD_len, block_idx<=0, ACTIVE next cycle.
REQ-021 ACTIVE: block_request=1, AD_cntrl=1, datalen=min(rem,RATE_BYTES), last_block=(rem<RATE_BYTES), pad_block=0.
REQ-022 ACTIVE with AD_read=1: rem<=rem-datalen, block_idx<=block_idx+1; next state DONE if rem<RATE_BYTES, PAD if rem==RATE_BYTES, else ACTIVE.
REQ-023 ACTIVE with AD_read=0: all registers and outputs hold.
REQ-024 PAD: block_request=1, AD_cntrl=1, datalen=0, last_block=1, pad_block=1; AD_read=1 -> block_idx+1, DONE.
REQ-025 DONE: block_request=0, AD_cntrl=0, datalen=0; ad_done=1 only in the first DONE cycle.
REQ-026 DONE SHALL persist while busy=1; busy=0 -> IDLE.
REQ-027 busy=0 in any state SHALL force IDLE next cycle, clear rem and block_idx, emit no ad_done.
REQ-028 AD_read SHALL be ignored in IDLE and DONE.
REQ-029 AD_len changes after sequence start SHALL be ignored.
REQ-030 Back-to-back AD_read=1 SHALL advance one block per cycle with no bubble.
REQ-031 Subtraction SHALL never underflow; rem reaches 0 only on exit to DONE or PAD.

Reset
REQ-032 nRST=0 SHALL asynchronously force IDLE, rem=0, block_idx=0, done flag=0; all outputs 0.
REQ-033 Reset deasserted mid-sequence SHALL restart from IDLE; the first busy=1 cycle after release is a fresh start.

Verification
REQ-034 RATE_BYTES=8, AD_len=0, busy=1 -> DONE next cycle, block_request never 1, ad_done high exactly 1 cycle.
REQ-035 RATE_BYTES=8, AD_len=5 -> one block datalen=5, last_block=1, block_idx=0; then DONE with ad_done pulse.
REQ-036 RATE_BYTES=8, AD_len=16, AD_read held 1 -> datalen 8,8,0 on consecutive cycles, block_idx 0,1,2; third block pad_block=1, last_block=1.
REQ-037 RATE_BYTES=8, AD_len=21 -> datalen 8,8,5; last_block only on third; no pad block. RATE_BYTES=16, AD_len=16 -> datalen 16 then pad block.
REQ-038 AD_len=255, AD_read stalled randomly -> 31 blocks datalen=8 then datalen=7 last_block=1; outputs stable while AD_read=0.
REQ-039 busy dropped after first accepted block of AD_len=24 -> IDLE next cycle, no ad_done; restart with AD_len=3 -> block_idx=0, datalen=3; nRST pulsed in ACTIVE -> all outputs 0 immediately.
